// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter that shares one RGB LED between NUM_REQ status sources, with a minimum
// dwell per grant. Optional idle heartbeat on blue: define RGB_ARB_IDLE_BLINK_EN.
module rgb_led_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 2_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_color,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   led_r,
    output logic                   led_g,
    output logic                   led_b,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShow
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   rr_ptr;

    logic               any_req;
    logic               found;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   win_idx;
    logic [2:0]         win_color;
    logic [NUM_REQ-1:0] win_onehot;
    logic               dwell_done;
    logic               do_grant;

    // Scan starts one past the last winner; the last winner itself is visited last.
    always_comb begin
        any_req  = |req;
        found    = 1'b0;
        scan_idx = rr_ptr;
        win_idx  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (scan_idx == PTR_MAX) ? '0 : scan_idx + PTR_W'(1);
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        win_color  = 3'b000;
        win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_color     = req_color[3*k +: 3];
                win_onehot[k] = 1'b1;
            end
        end
    end

    assign dwell_done = (cnt == CNT_MAX);
    assign do_grant   = any_req && ((state == StIdle) || dwell_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            cnt    <= '0;
            rr_ptr <= PTR_MAX;
            gnt    <= '0;
            led_r  <= 1'b0;
            led_g  <= 1'b0;
            led_b  <= 1'b0;
            busy   <= 1'b0;
        end else if (do_grant) begin
            // Covers both a fresh grant from idle and a back-to-back grant at dwell expiry.
            state                 <= StShow;
            cnt                   <= '0;
            rr_ptr                <= win_idx;
            gnt                   <= win_onehot;
            {led_r, led_g, led_b} <= win_color;
            busy                  <= 1'b1;
        end else if (state == StShow) begin
            if (dwell_done) begin
                state <= StIdle;
                cnt   <= '0;
                gnt   <= '0;
                led_r <= 1'b0;
                led_g <= 1'b0;
                led_b <= 1'b0;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
`ifdef RGB_ARB_IDLE_BLINK_EN
        else begin
            // Idle heartbeat reuses the dwell counter as its half-period timer.
            if (dwell_done) begin
                cnt   <= '0;
                led_b <= ~led_b;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter: directed vector table, async-reset and heartbeat sequences,
// then randomized traffic against a grant-list reference model.
module tb_rgb_led_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DWELL   = 8;
    localparam int CW      = 3 * NUM_REQ;

    localparam logic [CW-1:0] COL_A = 12'b110_001_010_100;
    localparam logic [CW-1:0] COL_B = 12'b110_001_111_100;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [CW-1:0]      req_color = '0;
    logic [NUM_REQ-1:0] gnt;
    logic               led_r, led_g, led_b, busy;

    int checks = 0;
    int errors = 0;

    rgb_led_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_color (req_color),
        .gnt       (gnt),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the LED, how many cycles are left, and idle time.
    int         m_holder;
    int         m_left;
    int         m_last;
    int         m_idle_t;
    logic [2:0] m_color;

    task automatic model_reset();
        m_holder = -1;
        m_left   = 0;
        m_last   = NUM_REQ - 1;
        m_idle_t = 0;
        m_color  = 3'b000;
    endtask

    task automatic model_step();
        bit was_idle;
        int pick;
        if (m_holder >= 0) begin
            m_left = m_left - 1;
            if (m_left > 0) return;
        end
        was_idle = (m_holder < 0);
        if (req != '0) begin
            pick = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (pick < 0 && req[(m_last + k) % NUM_REQ]) pick = (m_last + k) % NUM_REQ;
            end
            m_holder = pick;
            m_last   = pick;
            m_color  = req_color[3*pick +: 3];
            m_left   = DWELL;
        end else begin
            m_holder = -1;
            m_idle_t = was_idle ? m_idle_t + 1 : 0;
        end
    endtask

    function automatic logic [7:0] model_out();
        logic blink;
        blink = 1'b0;
`ifdef RGB_ARB_IDLE_BLINK_EN
        blink = ((m_idle_t / DWELL) % 2) == 1;
`endif
        if (m_holder >= 0) return {4'(1 << m_holder), m_color, 1'b1};
        return {4'b0000, 2'b00, blink, 1'b0};
    endfunction

    function automatic logic [7:0] dut_out();
        return {gnt, led_r, led_g, led_b, busy};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got gnt/rgb/busy=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic [CW-1:0]      col;
        int                 n;
        logic [NUM_REQ-1:0] gnt;
        logic [2:0]         led;
        logic               busy;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{4'b0001, COL_A, 24, 4'b0001, 3'b100, 1'b1};
        tbl[1]  = '{4'b0000, COL_A,  4, 4'b0000, 3'b000, 1'b0};
        tbl[2]  = '{4'b1111, COL_A,  8, 4'b0010, 3'b010, 1'b1};
        tbl[3]  = '{4'b1111, COL_A,  8, 4'b0100, 3'b001, 1'b1};
        tbl[4]  = '{4'b1111, COL_A,  8, 4'b1000, 3'b110, 1'b1};
        tbl[5]  = '{4'b1111, COL_A,  8, 4'b0001, 3'b100, 1'b1};
        tbl[6]  = '{4'b1111, COL_A,  8, 4'b0010, 3'b010, 1'b1};
        tbl[7]  = '{4'b0001, COL_A,  1, 4'b0001, 3'b100, 1'b1};
        tbl[8]  = '{4'b0000, COL_A,  7, 4'b0001, 3'b100, 1'b1};
        tbl[9]  = '{4'b0000, COL_A,  3, 4'b0000, 3'b000, 1'b0};
        tbl[10] = '{4'b0010, COL_A,  1, 4'b0010, 3'b010, 1'b1};
        tbl[11] = '{4'b0010, COL_B,  7, 4'b0010, 3'b010, 1'b1};
        tbl[12] = '{4'b0010, COL_B,  8, 4'b0010, 3'b111, 1'b1};
        tbl[13] = '{4'b0000, COL_B,  8, 4'b0000, 3'b000, 1'b0};
        tbl[14] = '{4'b1000, COL_A,  1, 4'b1000, 3'b110, 1'b1};
        tbl[15] = '{4'b0101, COL_A,  7, 4'b1000, 3'b110, 1'b1};
        tbl[16] = '{4'b0101, COL_A,  8, 4'b0001, 3'b100, 1'b1};
        tbl[17] = '{4'b0101, COL_A,  8, 4'b0100, 3'b001, 1'b1};
        tbl[18] = '{4'b0000, COL_A,  8, 4'b0000, 3'b000, 1'b0};

        model_reset();
        @(negedge clk);
        check("reset_state", dut_out(), 8'b0);
        check("model", dut_out(), model_out());
        #2 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            req       = tbl[i].req;
            req_color = tbl[i].col;
            repeat (tbl[i].n) begin
                cycle();
                check($sformatf("tbl%0d", i), dut_out(),
                      {tbl[i].gnt, tbl[i].led, tbl[i].busy});
            end
        end

        // Asynchronous reset three cycles into a dwell, then priority returns to requester 0.
        req       = 4'b1111;
        req_color = COL_A;
        repeat (4) cycle();
        check("pre_rst", dut_out(), {4'b1000, 3'b110, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async_rst", dut_out(), 8'b0);
        model_reset();
        @(negedge clk);
        check("held_rst", dut_out(), 8'b0);
        rst_n = 1'b1;
        cycle();
        check("rr_after_rst", dut_out(), {4'b0001, 3'b100, 1'b1});

`ifdef RGB_ARB_IDLE_BLINK_EN
        req = '0;
        do_reset();
        for (int t = 0; t < 32; t++) begin
            if (t > 0) cycle();
            check($sformatf("blink%0d", t), {4'b0000, led_r, led_g, led_b, busy},
                  {4'b0000, 2'b00, 1'((t / DWELL) % 2), 1'b0});
        end
`endif

        req = '0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                req = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom());
            end
            if ($urandom_range(0, 3) == 0) req_color = CW'($urandom());
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
